weight_load_ctrl: RTL

Sequencer directly upstream of the local weight buffer. It takes a 16-bit weight word stream through a valid/ready handshake and runs the per-layer store sequence. It drives the buffer's write_weight_signal/data/addr, weight_fsm_cs and weight_store_done. It loads exactly one layer's weight set per start command.

---
 rtl/weight_pkg.sv | 55 +++++
 rtl/counter_cnn.sv | 23 ++
 rtl/weight_load_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/weight_pkg.sv
// Shared definitions for the weight load path: state encodings (also decoded
// by the weight buffer), per-layer word counts and layer_sel encodings.
package weight_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'b0000,
    L1_STORE = 4'b0001,
    L2_STORE = 4'b0010,
    L4_STORE = 4'b0011,
    L5_STORE = 4'b0100,
    L7_STORE = 4'b0101,
    FINISH   = 4'b1111
  } state_t;

  localparam logic [15:0] L1_WORDS = 16'd216;  // 72 entries x 3 channels
  localparam logic [15:0] L8_WORDS = 16'd576;  // 72 entries x 8 channels
  localparam logic [15:0] L7_WORDS = 16'd400;  // 50 entries x 8 channels

  localparam logic [2:0] SEL_L1 = 3'd1;
  localparam logic [2:0] SEL_L2 = 3'd2;
  localparam logic [2:0] SEL_L4 = 3'd4;
  localparam logic [2:0] SEL_L5 = 3'd5;
  localparam logic [2:0] SEL_L7 = 3'd7;

  function automatic logic layer_valid(input logic [2:0] sel);
    return (sel == SEL_L1) || (sel == SEL_L2) || (sel == SEL_L4) ||
           (sel == SEL_L5) || (sel == SEL_L7);
  endfunction

  function automatic state_t layer_state(input logic [2:0] sel);
    case (sel)
      SEL_L1:  return L1_STORE;
      SEL_L2:  return L2_STORE;
      SEL_L4:  return L4_STORE;
      SEL_L5:  return L5_STORE;
      SEL_L7:  return L7_STORE;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [15:0] layer_words(input logic [2:0] sel);
    case (sel)
      SEL_L1:                 return L1_WORDS;
      SEL_L2, SEL_L4, SEL_L5: return L8_WORDS;
      SEL_L7:                 return L7_WORDS;
      default:                return 16'd0;
    endcase
  endfunction

  function automatic logic is_store_state(input state_t s);
    return (s == L1_STORE) || (s == L2_STORE) || (s == L4_STORE) ||
           (s == L5_STORE) || (s == L7_STORE);
  endfunction

endpackage

// File: rtl/counter_cnn.sv
// Generic up-counter: synchronous clear has priority over increment,
// otherwise the value holds.
module counter_cnn #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count register with async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Weight load sequencer: accepts one layer's weight words over valid/ready
// and drives registered write strobe/data/addr into the weight buffer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; invalid layer_sel pulses cmd_err
// Lx_STORE | accepting words for layer x; stays through the final write
// FINISH   | one cycle, weight_store_done high; counter cleared on exit
module weight_load_ctrl
  import weight_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  layer_sel,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        write_weight_signal,
  output logic [15:0] write_weight_data,
  output logic [15:0] write_weight_addr,
  output logic [3:0]  weight_fsm_cs,
  output logic        weight_store_done,
  output logic        busy,
  output logic        cmd_err
);

  state_t      state;
  logic [15:0] n_words;
  logic [15:0] cnt;
  logic        last_flag;
  logic        accept;
  logic        cnt_clr;

  assign in_ready      = is_store_state(state) && !last_flag;
  assign accept        = in_valid && in_ready;
  assign cnt_clr       = (state == FINISH);
  assign weight_fsm_cs = state;
  assign busy          = (state != IDLE);

  counter_cnn #(.W(16)) u_word_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (accept),
    .cnt (cnt)
  );

  // Sequencer state, layer length and registered buffer-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      n_words             <= 16'd0;
      last_flag           <= 1'b0;
      write_weight_signal <= 1'b0;
      write_weight_data   <= 16'd0;
      write_weight_addr   <= 16'd0;
      weight_store_done   <= 1'b0;
      cmd_err             <= 1'b0;
    end else begin
      write_weight_signal <= accept;
      weight_store_done   <= 1'b0;
      cmd_err             <= 1'b0;

      if (accept) begin
        write_weight_data <= in_data;
        write_weight_addr <= cnt;
        if (cnt == n_words - 16'd1)
          last_flag <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (layer_valid(layer_sel)) begin
              state   <= layer_state(layer_sel);
              n_words <= layer_words(layer_sel);
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        L1_STORE, L2_STORE, L4_STORE, L5_STORE, L7_STORE: begin
          // last_flag is set on the final accept, so this cycle carries the
          // final write while the store state is still visible to the buffer
          if (last_flag) begin
            state             <= FINISH;
            weight_store_done <= 1'b1;
          end
        end
        FINISH: begin
          state     <= IDLE;
          last_flag <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          last_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule
